// File: rtl/clken_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clken_pkg: shared state encoding and default sizing for clken_div_*  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package clken_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DIV_W_DEF    = 8;
    localparam int CNT_W_DEF    = 4;
    localparam int DIV_INIT_DEF = 4;

endpackage
`default_nettype wire

// File: rtl/clken_div_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clken_div_core: programmable divider emitting a one-cycle enable     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module clken_div_core
    import clken_pkg::*;
#(
    parameter int DIV_W    = DIV_W_DEF,
    parameter int DIV_INIT = DIV_INIT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             mode_oneshot,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_load,
    output logic             clk_en,
    output state_t           state
);

    localparam logic [DIV_W-1:0] c_div_init = DIV_W'(DIV_INIT);

    state_t           r_state;
    logic [DIV_W-1:0] r_divcnt;
    logic [DIV_W-1:0] r_div_act;
    logic [DIV_W-1:0] r_shadow;
    logic             r_pending;
    logic             r_oneshot;
    logic             r_clk_en;
    logic             w_terminal;
    logic             w_div_boundary;

    assign w_terminal     = (r_state == ST_RUN) && (r_divcnt == r_div_act);
    // The active divisor may only change while idle or as a period completes.
    assign w_div_boundary = (r_state == ST_IDLE) || w_terminal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_divcnt  <= '0;
            r_div_act <= c_div_init;
            r_shadow  <= c_div_init;
            r_pending <= 1'b0;
            r_oneshot <= 1'b0;
            r_clk_en  <= 1'b0;
        end else begin
            r_clk_en <= 1'b0;

            if (div_load) begin
                r_shadow <= div_val;
                if (w_div_boundary) begin
                    r_div_act <= div_val;
                    r_pending <= 1'b0;
                end else begin
                    r_pending <= 1'b1;
                end
            end else if (r_pending && w_div_boundary) begin
                r_div_act <= r_shadow;
                r_pending <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    r_divcnt <= '0;
                    if (start && !stop) begin
                        r_state   <= ST_RUN;
                        r_oneshot <= mode_oneshot;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        r_state  <= ST_IDLE;
                        r_divcnt <= '0;
                    end else if (start) begin
                        r_divcnt  <= '0;
                        r_oneshot <= mode_oneshot;
                    end else if (w_terminal) begin
                        r_divcnt <= '0;
                        r_clk_en <= 1'b1;
                        if (r_oneshot) begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_divcnt <= r_divcnt + DIV_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign clk_en = r_clk_en;
    assign state  = r_state;

endmodule
`default_nettype wire

// File: rtl/clken_div_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clken_div_cnt: programmable clock-enable generator + event counter   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module clken_div_cnt
    import clken_pkg::*;
#(
    parameter int DIV_W    = DIV_W_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int DIV_INIT = DIV_INIT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             mode_oneshot,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_load,
    input  logic [CNT_W-1:0] cnt_max,
    input  logic             clr_cnt,
    output logic             clk_en,
    output logic [CNT_W-1:0] syscnt,
    output logic             cnt_wrap,
    output logic             busy
);

    state_t           w_state;
    logic             w_clk_en;
    logic [CNT_W-1:0] r_syscnt;
    logic             r_cnt_wrap;

    clken_div_core #(
        .DIV_W    (DIV_W),
        .DIV_INIT (DIV_INIT)
    ) u_core (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .mode_oneshot (mode_oneshot),
        .div_val      (div_val),
        .div_load     (div_load),
        .clk_en       (w_clk_en),
        .state        (w_state)
    );

    // Counts registered enables regardless of divider state, so a pulse
    // already in flight when stop arrives is still consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_syscnt   <= '0;
            r_cnt_wrap <= 1'b0;
        end else if (clr_cnt) begin
            r_syscnt   <= '0;
            r_cnt_wrap <= 1'b0;
        end else if (w_clk_en) begin
            if (r_syscnt == cnt_max) begin
                r_syscnt   <= '0;
                r_cnt_wrap <= 1'b1;
            end else begin
                r_syscnt   <= r_syscnt + CNT_W'(1);
                r_cnt_wrap <= 1'b0;
            end
        end else begin
            r_cnt_wrap <= 1'b0;
        end
    end

    assign clk_en   = w_clk_en;
    assign syscnt   = r_syscnt;
    assign cnt_wrap = r_cnt_wrap;
    assign busy     = (w_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_clken_div_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_clken_div_cnt: vector-table bench with expected-value queue       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_clken_div_cnt;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, stop, mode_oneshot, div_load, clr_cnt;
    logic [7:0] div_val;
    logic [3:0] cnt_max;
    logic       clk_en, cnt_wrap, busy;
    logic [3:0] syscnt;

    clken_div_cnt #(
        .DIV_W    (8),
        .CNT_W    (4),
        .DIV_INIT (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .mode_oneshot (mode_oneshot),
        .div_val      (div_val),
        .div_load     (div_load),
        .cnt_max      (cnt_max),
        .clr_cnt      (clr_cnt),
        .clk_en       (clk_en),
        .syscnt       (syscnt),
        .cnt_wrap     (cnt_wrap),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         st, sp, mo;
        logic [7:0] dv;
        bit         dl;
        logic [3:0] cm;
        bit         cl;
        bit         en, bz;
    } vec_t;

    typedef struct {
        logic       en;
        logic [3:0] cnt;
        logic       wrap;
        logic       bz;
    } exp_t;

    vec_t       tbl[$];
    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [3:0] m_cnt;
    logic       m_en;
    string      seg;

    task automatic add(input bit st, sp, mo, input logic [7:0] dv, input bit dl,
                       input logic [3:0] cm, input bit cl, input bit en, bz);
        vec_t v;
        v.st = st; v.sp = sp; v.mo = mo; v.dv = dv; v.dl = dl;
        v.cm = cm; v.cl = cl; v.en = en; v.bz = bz;
        tbl.push_back(v);
    endtask

    task automatic add_wait(input int n, input logic [3:0] cm, input bit bz);
        for (int i = 0; i < n; i++) add(0, 0, 0, 8'd0, 0, cm, 0, 0, bz);
    endtask

    task automatic add_pulse(input logic [3:0] cm, input bit bz);
        add(0, 0, 0, 8'd0, 0, cm, 0, 1, bz);
    endtask

    task automatic idle_inputs();
        start = 0; stop = 0; mode_oneshot = 0; div_load = 0; clr_cnt = 0;
        div_val = 8'd0; cnt_max = 4'd15;
    endtask

    task automatic chk_zero(input string nm);
        n_cmp++;
        if (clk_en !== 1'b0 || syscnt !== 4'd0 || cnt_wrap !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: got en=%b cnt=%0d wrap=%b busy=%b, want all zero",
                     nm, clk_en, syscnt, cnt_wrap, busy);
        end
    endtask

    task automatic run_table();
        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            exp_t e;
            v = tbl[i];
            @(negedge clk);
            start = v.st; stop = v.sp; mode_oneshot = v.mo; div_val = v.dv;
            div_load = v.dl; cnt_max = v.cm; clr_cnt = v.cl;
            // Expected counter state follows from the enable seen one edge earlier.
            e.wrap = 1'b0;
            if (v.cl) begin
                e.cnt = 4'd0;
            end else if (m_en) begin
                if (m_cnt == v.cm) begin
                    e.cnt  = 4'd0;
                    e.wrap = 1'b1;
                end else begin
                    e.cnt = m_cnt + 4'd1;
                end
            end else begin
                e.cnt = m_cnt;
            end
            e.en = v.en;
            e.bz = v.bz;
            m_cnt = e.cnt;
            m_en  = v.en;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (clk_en !== e.en || syscnt !== e.cnt || cnt_wrap !== e.wrap || busy !== e.bz) begin
                n_bad++;
                $display("FAIL %s vec%0d: got en=%b cnt=%0d wrap=%b busy=%b, want en=%b cnt=%0d wrap=%b busy=%b",
                         seg, i, clk_en, syscnt, cnt_wrap, busy, e.en, e.cnt, e.wrap, e.bz);
            end
        end
        tbl.delete();
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        m_cnt = 4'd0;
        m_en  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Continuous divide-by-5, full 16-count wrap, stop with a pulse in flight.
        seg = "continuous";
        add(1, 0, 0, 8'd0, 0, 4'd15, 0, 0, 1);
        for (int p = 0; p < 17; p++) begin
            add_wait(4, 4'd15, 1);
            add_pulse(4'd15, 1);
        end
        add(0, 1, 0, 8'd0, 0, 4'd15, 0, 0, 0);
        add(0, 0, 0, 8'd0, 0, 4'd15, 1, 0, 0);
        run_table();

        // Shadowed divisor: 5 -> 3, then two loads where the last (6) wins.
        seg = "reshape";
        add(1, 0, 0, 8'd0, 0, 4'd15, 0, 0, 1);
        add_wait(4, 4'd15, 1);
        add_pulse(4'd15, 1);
        add_wait(1, 4'd15, 1);
        add(0, 0, 0, 8'd2, 1, 4'd15, 0, 0, 1);
        add_wait(2, 4'd15, 1);
        add_pulse(4'd15, 1);
        for (int p = 0; p < 3; p++) begin
            add_wait(2, 4'd15, 1);
            add_pulse(4'd15, 1);
        end
        add(0, 0, 0, 8'd3, 1, 4'd15, 0, 0, 1);
        add(0, 0, 0, 8'd6, 1, 4'd15, 0, 0, 1);
        add_pulse(4'd15, 1);
        add_wait(6, 4'd15, 1);
        add_pulse(4'd15, 1);
        add_wait(6, 4'd15, 1);
        add_pulse(4'd15, 1);
        add(0, 1, 0, 8'd0, 0, 4'd15, 0, 0, 0);
        run_table();

        // One-shot with divisor 3 loaded while idle; stop in IDLE is harmless.
        seg = "oneshot";
        add(0, 0, 0, 8'd3, 1, 4'd15, 0, 0, 0);
        add(1, 0, 1, 8'd0, 0, 4'd15, 0, 0, 1);
        add_wait(3, 4'd15, 1);
        add_pulse(4'd15, 0);
        add_wait(25, 4'd15, 0);
        add(0, 1, 0, 8'd0, 0, 4'd15, 0, 0, 0);
        add_wait(25, 4'd15, 0);
        run_table();

        // Divisor 0 (enable every cycle), small cnt_max, clr vs enable, lowered cnt_max.
        seg = "counter";
        add(0, 0, 0, 8'd0, 1, 4'd2, 1, 0, 0);
        add(1, 0, 0, 8'd0, 0, 4'd2, 0, 0, 1);
        for (int p = 0; p < 6; p++) add_pulse(4'd2, 1);
        add(0, 0, 0, 8'd0, 0, 4'd2, 1, 1, 1);
        for (int p = 0; p < 5; p++) add_pulse(4'd15, 1);
        for (int p = 0; p < 14; p++) add_pulse(4'd2, 1);
        add(0, 1, 0, 8'd0, 0, 4'd2, 0, 0, 0);
        run_table();

        // Control collisions.
        seg = "collide";
        add(0, 0, 0, 8'd4, 1, 4'd15, 0, 0, 0);
        add(1, 0, 0, 8'd0, 0, 4'd15, 0, 0, 1);
        add_wait(4, 4'd15, 1);
        add(0, 1, 0, 8'd0, 0, 4'd15, 0, 0, 0);
        add_wait(6, 4'd15, 0);
        add(1, 1, 0, 8'd0, 0, 4'd15, 0, 0, 0);
        add_wait(3, 4'd15, 0);
        add(1, 0, 0, 8'd0, 0, 4'd15, 0, 0, 1);
        add_wait(3, 4'd15, 1);
        add(1, 0, 0, 8'd0, 0, 4'd15, 0, 0, 1);
        add_wait(4, 4'd15, 1);
        add_pulse(4'd15, 1);
        add(0, 1, 0, 8'd0, 0, 4'd15, 0, 0, 0);
        run_table();

        // Run with divisor 2 until syscnt=7 and clk_en=1, then reset between edges.
        seg = "prereset";
        add(0, 0, 0, 8'd2, 1, 4'd15, 1, 0, 0);
        add(1, 0, 0, 8'd0, 0, 4'd15, 0, 0, 1);
        for (int p = 0; p < 8; p++) begin
            add_wait(2, 4'd15, 1);
            add_pulse(4'd15, 1);
        end
        tbl[tbl.size()-1].sp = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            @(negedge clk);
            v = tbl[i];
            start = v.st; stop = v.sp; mode_oneshot = v.mo; div_val = v.dv;
            div_load = v.dl; cnt_max = v.cm; clr_cnt = v.cl;
            @(posedge clk);
        end
        tbl.delete();
        #2;
        n_cmp++;
        if (clk_en !== 1'b1 || syscnt !== 4'd7 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL prereset: got en=%b cnt=%0d busy=%b, want en=1 cnt=7 busy=1",
                     clk_en, syscnt, busy);
        end
        rst = 1'b1;
        #1;
        chk_zero("async_reset");
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        m_cnt = 4'd0;
        m_en  = 1'b0;

        seg = "postreset";
        add(1, 0, 0, 8'd0, 0, 4'd15, 0, 0, 1);
        add_wait(4, 4'd15, 1);
        add_pulse(4'd15, 1);
        add_wait(1, 4'd15, 1);
        add(0, 1, 0, 8'd0, 0, 4'd15, 0, 0, 0);
        run_table();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clken_div_cnt.md
Name: clken_div_cnt

Overview:
Parametrised successor to the fixed divide-by-5 clock-enable plus 4-bit counter block. It generates a single-cycle clock-enable pulse from `clk` with a runtime-programmable period. It supports continuous or one-shot operation, start/stop control, and glitch-free shadowed divisor updates. A wrapping event counter advances on each enable. It feeds slow-rate logic in the same clock domain; it is not a clock source.

Parameters:
DIV_W, 8, width of divider counter and divisor; period = div_val+1 cycles
CNT_W, 4, width of event counter syscnt
DIV_INIT, 4, divisor loaded on reset (divide-by-5)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  pulse; begin/re-phase divider, latches mode_oneshot
stop  in  1  pulse; return to IDLE
mode_oneshot  in  1  1 = emit exactly one enable then stop; sampled only on start
div_val  in  DIV_W  new divisor
div_load  in  1  pulse; capture div_val into shadow
cnt_max  in  CNT_W  terminal value of syscnt
clr_cnt  in  1  synchronous clear of syscnt
clk_en  out  1  one-cycle enable pulse, registered
syscnt  out  CNT_W  event counter
cnt_wrap  out  1  one-cycle pulse, registered; high in the cycle syscnt shows 0 after wrap
busy  out  1  high in RUN

Behaviour:
- Reset (async, immediate): state=IDLE, divcnt=0, div_act=DIV_INIT, shadow pending=0, clk_en=0, syscnt=0, cnt_wrap=0, busy=0, oneshot latch=0.
- States: IDLE, RUN. busy = (state==RUN).
- IDLE:
  - divcnt held 0; clk_en=0.
  - start -> RUN, divcnt<=0, oneshot latch<=mode_oneshot.
- RUN:
  - Terminal = (divcnt==div_act).
  - Non-terminal edge: divcnt<=divcnt+1.
  - Terminal edge: divcnt<=0, clk_en<=1 (0 on all other edges).
  - Timing with start sampled at edge T0: clk_en is high after edge T(div_act+1), then every div_act+1 cycles.
  - div_act=0: clk_en high every cycle.
  - Terminal edge with oneshot latch=1: state->IDLE. Exactly one clk_en pulse per start.
- stop in RUN: ->IDLE, divcnt<=0, clk_en<=0.
  - stop beats a coincident terminal (no pulse).
  - stop beats a coincident start.
  - stop in IDLE: no effect.
- start in RUN: re-phase with divcnt<=0, no pulse on that edge, oneshot re-latched.
- Divisor update:
  - div_load captures shadow<=div_val and sets pending.
  - In IDLE, the value applies to div_act at the same edge, with no pending.
  - In RUN, pending applies at the next terminal edge. The current period always completes at the old length.
  - div_load on a terminal edge: the new div_val is applied directly at that edge.
  - A second div_load before the boundary overwrites the shadow; last value wins.
- Counter, evaluated each edge in priority order:
  - clr_cnt: syscnt<=0, cnt_wrap<=0.
  - Else if clk_en==1:
    - If syscnt==cnt_max: syscnt<=0, cnt_wrap<=1.
    - Else syscnt<=syscnt+1, cnt_wrap<=0.
  - Else: hold, cnt_wrap<=0.
  - cnt_max=0: syscnt stays 0 and cnt_wrap pulses on every consumed enable.
  - cnt_max lowered below the current syscnt: counting continues to 2^CNT_W-1, then rolls to 0 via natural overflow with no cnt_wrap, and runs normally afterwards.
- Counter timing: syscnt changes one edge after clk_en is high. A clk_en already registered when stop arrives is still counted. The counter runs independently of state.
- Widths: all arithmetic is modulo its own register width; no saturation.

Decomposition:
- Shared header/package clken_pkg:
  - State encodings ST_IDLE=1'b0, ST_RUN=1'b1.
  - Default constants DIV_W_DEF, CNT_W_DEF, DIV_INIT_DEF.
- Sub-module clken_div_core holds:
  - State machine, divcnt, shadow/pending and div_act, clk_en register.
- Top clken_div_cnt holds:
  - clken_div_core instance, syscnt/cnt_wrap logic and busy.

Test Plan:
1. Continuous mode, reset with DIV_INIT=4, cnt_max=15, start at T0 -> clk_en high after T5, T10, T15…; syscnt 1,2,…,15,0; cnt_wrap high only with the 15->0 transition.
2. Reshaping with div_act=4: div_load div_val=2 while divcnt=1 -> current pulse still 5 cycles from previous pulse, following pulses every 3 cycles. A second load of 6 before the boundary -> period 7 used instead.
3. One-shot mode, mode_oneshot=1, div_val=3 loaded in IDLE, start -> single clk_en after T4, busy falls at T4, syscnt=1, no further pulses over 50 cycles.
4. Counter edges:
   - cnt_max=2 -> syscnt 0,1,2,0 with cnt_wrap on the 2->0 edge.
   - clr_cnt coincident with clk_en at syscnt=2 -> syscnt=0, cnt_wrap=0.
5. Control collisions:
   - stop on a terminal edge -> no clk_en.
   - start+stop same cycle from IDLE -> stays IDLE.
   - div_val=0 -> clk_en high every cycle in RUN.
   - start in RUN at divcnt=3 -> next pulse div_act+1 cycles later.
6. Reset mid-run: assert rst between clock edges while clk_en=1, syscnt=7 -> all outputs 0 immediately, div_act=4, pending cleared. Release and start -> first pulse after T5.
